// File: rtl/hs_arb_pkg.sv
// Shared constants and helpers for the round-robin handshake arbiter.
// Imported by hs_rr_pick and hs_rr_arbiter.
package hs_arb_pkg;

  localparam int HS_ARB_MAX_REQ = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational round-robin picker: double-width masked priority encoder.
// Searches upward from ptr+1, wrapping, and returns a one-hot grant.
module hs_rr_pick
  import hs_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    win_idx_o
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;
  logic                 found;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(ptr_i));
    end
    // Low half: requests above ptr; high half: wrapped requests.
    dbl       = {req_i, req_i & mask};
    grant_o   = '0;
    win_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (!found && dbl[i]) begin
        found                = 1'b1;
        grant_o[i % NUM_REQ] = 1'b1;
        win_idx_o            = ID_W'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with registered output stage.
// Define HS_ARB_PKT_LOCK_EN to hold the grant until a beat with last=1.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
`ifdef HS_ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic                      m_last_o,
`endif
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      m_valid_o,
  output logic [DATA_W-1:0]         m_data_o,
  output logic [ID_W-1:0]           m_id_o,
  input  logic                      m_ready_i
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ID_W-1:0]   m_id_q, m_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_grant, sel_grant;
  logic [ID_W-1:0]    pick_idx, sel_idx;
  logic [DATA_W-1:0]  win_data;
  logic               load_en, up_xfer, sel_last;

`ifdef HS_ARB_PKT_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_idx_q, lock_idx_d;
  logic            m_last_q, m_last_d;
`endif

  hs_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .grant_o   (pick_grant),
    .win_idx_o (pick_idx)
  );

  always_comb begin
    sel_idx   = pick_idx;
    sel_grant = pick_grant;
    sel_last  = 1'b1;
`ifdef HS_ARB_PKT_LOCK_EN
    if (lock_q) begin
      sel_idx   = lock_idx_q;
      sel_grant = req_valid_i & (NUM_REQ'(1) << lock_idx_q);
    end
    sel_last = req_last_i[sel_idx];
`endif
    load_en     = ~m_valid_q | m_ready_i;
    req_ready_o = sel_grant & {NUM_REQ{load_en}};
    up_xfer     = |req_ready_o;
    win_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel_idx) begin
        win_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    ptr_d     = ptr_q;
`ifdef HS_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    m_last_d   = m_last_q;
`endif
    if (up_xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = win_data;
      m_id_d    = sel_idx;
      // ptr only advances at a packet boundary.
      if (sel_last) begin
        ptr_d = sel_idx;
      end
`ifdef HS_ARB_PKT_LOCK_EN
      lock_d     = ~sel_last;
      lock_idx_d = sel_idx;
      m_last_d   = sel_last;
`endif
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      ptr_q     <= ID_W'(NUM_REQ-1);
`ifdef HS_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      m_last_q   <= 1'b0;
`endif
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      ptr_q     <= ptr_d;
`ifdef HS_ARB_PKT_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      m_last_q   <= m_last_d;
`endif
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_id_o    = m_id_q;
`ifdef HS_ARB_PKT_LOCK_EN
  assign m_last_o  = m_last_q;
`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter (NUM_REQ=4, DATA_W=8).
// Packet-lock steps run only when HS_ARB_PKT_LOCK_EN is defined.
module tb_hs_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_id;
  logic        m_ready;
`ifdef HS_ARB_PKT_LOCK_EN
  logic [3:0]  req_last;
  logic        m_last;
`endif

  int checks = 0;
  int errors = 0;

  hs_rr_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
`ifdef HS_ARB_PKT_LOCK_EN
    .req_last_i  (req_last),
    .m_last_o    (m_last),
`endif
    .req_ready_o (req_ready),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .m_id_o      (m_id),
    .m_ready_i   (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] id,
                      input logic [7:0] data);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_id"}, 32'(m_id), 32'(id));
    chk({tag, "_data"}, 32'(m_data), 32'(data));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    m_ready   = 1'b1;
`ifdef HS_ARB_PKT_LOCK_EN
    req_last  = 4'b1111;
`endif
    tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_id", 32'(m_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'b0001);

    // All requesters valid: ids 0,1,2,3,0 back-to-back.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      beat("rr", 2'(i % 4), 8'h10 + 8'(i % 4));
    end

    // Downstream stall for 3 clocks.
    m_ready = 1'b0;
    #1;
    chk("stall_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("stall", 2'd0, 8'h10);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    m_ready = 1'b1;
    #1;
    chk("release_ready", 32'(req_ready), 32'b0010);
    tick();
    beat("release", 2'd1, 8'h11);

    // Async reset while stalled.
    m_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_id", 32'(m_id), 32'd0);
    req_valid = 4'b1010;
    m_ready   = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    beat("arst_first", 2'd1, 8'h11);

    // Reqs 1 and 3 alternate with ptr=1.
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k % 2 == 0) beat("alt", 2'd3, 8'h13);
      else            beat("alt", 2'd1, 8'h11);
    end

    // Single requester 2, back-to-back beats.
    req_valid = 4'b0100;
    req_data[16 +: 8] = 8'hA5;
    #1;
    chk("solo_ready", 32'(req_ready), 32'b0100);
    tick();
    beat("solo_a5", 2'd2, 8'hA5);
    req_data[16 +: 8] = 8'hA6;
    #1;
    chk("solo_ready2", 32'(req_ready), 32'b0100);
    tick();
    beat("solo_a6", 2'd2, 8'hA6);
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(m_valid), 32'd0);
    chk("drain_hold", 32'(m_data), 32'hA6);

`ifdef HS_ARB_PKT_LOCK_EN
    // Req 0 sends a 3-beat packet while req 1 waits.
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b0011;
    req_last  = 4'b1110;
    tick();
    beat("pkt_b1", 2'd0, 8'h10);
    chk("pkt_b1_last", 32'(m_last), 32'd0);
    tick();
    beat("pkt_b2", 2'd0, 8'h10);
    req_valid = 4'b0010;
    #1;
    chk("pkt_gap_ready", 32'(req_ready), 32'd0);
    tick();
    chk("pkt_gap_valid", 32'(m_valid), 32'd0);
    req_valid = 4'b0011;
    req_last  = 4'b1111;
    tick();
    beat("pkt_b3", 2'd0, 8'h10);
    chk("pkt_b3_last", 32'(m_last), 32'd1);
    tick();
    beat("pkt_next", 2'd1, 8'h11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
